memory_double: RTL and testbench



---
 rtl/memory_double_pkg.sv | 9 +
 rtl/memory_double_port.sv | 31 +++
 rtl/memory_double.sv | 79 +++++++
 tb/tb_memory_double.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/memory_double_pkg.sv
// Shared constants and word type for the dual-port projection-vector store.
package memory_double_pkg;

  localparam int DATA_WIDTH_DEF = 16;
  localparam int ADDR_WIDTH_DEF = 8;

  typedef logic [DATA_WIDTH_DEF-1:0] word_t;

endpackage

// File: rtl/memory_double_port.sv
// One RAM port: cs/we/oe decode into write/read strobes plus the registered read data.
// Read data lands one edge after the read is sampled; no handshake, a new op every cycle.
module memory_double_port
  import memory_double_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cs,
  input  logic                  we,
  input  logic                  oe,
  input  logic [DATA_WIDTH-1:0] rd_word,
  output logic                  wr_stb,
  output logic                  rd_stb,
  output logic [DATA_WIDTH-1:0] data_out
);

  // Write enable wins over output enable, so a port never reads and writes together.
  assign wr_stb = cs & we;
  assign rd_stb = cs & oe & ~we;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_out <= '0;
    end else if (rd_stb) begin
      data_out <= rd_word;
    end
  end

endmodule

// File: rtl/memory_double.sv
// Dual-port synchronous RAM, one shared array, two independent read/write ports.
// Writes land at the sampling edge; reads return 1 cycle later; no backpressure.
module memory_double
  import memory_double_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DEPTH      = 2 ** ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] address_0,
  input  logic [DATA_WIDTH-1:0] data_0_in,
  output logic [DATA_WIDTH-1:0] data_0_out,
  input  logic                  cs_0,
  input  logic                  we_0,
  input  logic                  oe_0,
  input  logic [ADDR_WIDTH-1:0] address_1,
  input  logic [DATA_WIDTH-1:0] data_1_in,
  output logic [DATA_WIDTH-1:0] data_1_out,
  input  logic                  cs_1,
  input  logic                  we_1,
  input  logic                  oe_1
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic wr_stb_0, rd_stb_0;
  logic wr_stb_1, rd_stb_1;
  logic wr_keep_0;

  // Port 1 owns the location when both ports write the same address.
  assign wr_keep_0 = wr_stb_0 & ~(wr_stb_1 & (address_0 == address_1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (wr_keep_0) begin
        mem[address_0] <= data_0_in;
      end
      if (wr_stb_1) begin
        mem[address_1] <= data_1_in;
      end
    end
  end

  // Read words come straight from the array, so a cross-port read in a write cycle sees old data.
  memory_double_port #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_port_0 (
    .clk     (clk),
    .reset   (reset),
    .cs      (cs_0),
    .we      (we_0),
    .oe      (oe_0),
    .rd_word (mem[address_0]),
    .wr_stb  (wr_stb_0),
    .rd_stb  (rd_stb_0),
    .data_out(data_0_out)
  );

  memory_double_port #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_port_1 (
    .clk     (clk),
    .reset   (reset),
    .cs      (cs_1),
    .we      (we_1),
    .oe      (oe_1),
    .rd_word (mem[address_1]),
    .wr_stb  (wr_stb_1),
    .rd_stb  (rd_stb_1),
    .data_out(data_1_out)
  );

endmodule

// File: tb/tb_memory_double.sv
// Self-checking bench for memory_double: directed vector table plus randomized traffic vs a reference model.
module tb_memory_double;
  import memory_double_pkg::*;

  logic        clk;
  logic        reset;
  logic [7:0]  address_0, address_1;
  word_t       data_0_in, data_1_in;
  word_t       data_0_out, data_1_out;
  logic        cs_0, we_0, oe_0;
  logic        cs_1, we_1, oe_1;

  int checks;
  int failures;

  // Reference model: plain array of words and last-read values per port.
  word_t mref [256];
  word_t mout0, mout1;

  typedef struct {
    logic       c0, w0, o0;
    logic [7:0] a0;
    word_t      d0;
    logic       c1, w1, o1;
    logic [7:0] a1;
    word_t      d1;
    word_t      exp0, exp1;
  } vec_t;

  vec_t vecs [$];

  memory_double dut (
    .clk       (clk),
    .reset     (reset),
    .address_0 (address_0),
    .data_0_in (data_0_in),
    .data_0_out(data_0_out),
    .cs_0      (cs_0),
    .we_0      (we_0),
    .oe_0      (oe_0),
    .address_1 (address_1),
    .data_1_in (data_1_in),
    .data_1_out(data_1_out),
    .cs_1      (cs_1),
    .we_1      (we_1),
    .oe_1      (oe_1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input word_t act, input word_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 256; i++) mref[i] = '0;
    mout0 = '0;
    mout1 = '0;
  endtask

  // Drive one cycle of stimulus, let the edge happen, update the model, sample #1 later.
  task automatic apply(input logic c0, input logic w0, input logic o0, input logic [7:0] a0,
                       input word_t d0, input logic c1, input logic w1, input logic o1,
                       input logic [7:0] a1, input word_t d1);
    word_t old0, old1;
    @(negedge clk);
    cs_0 = c0; we_0 = w0; oe_0 = o0; address_0 = a0; data_0_in = d0;
    cs_1 = c1; we_1 = w1; oe_1 = o1; address_1 = a1; data_1_in = d1;
    @(posedge clk);
    old0 = mref[a0];
    old1 = mref[a1];
    if (c0 && o0 && !w0) mout0 = old0;
    if (c1 && o1 && !w1) mout1 = old1;
    if (c0 && w0) mref[a0] = d0;
    if (c1 && w1) mref[a1] = d1;
    #1;
  endtask

  task automatic idle_inputs();
    cs_0 = 0; we_0 = 0; oe_0 = 0; address_0 = '0; data_0_in = '0;
    cs_1 = 0; we_1 = 0; oe_1 = 0; address_1 = '0; data_1_in = '0;
  endtask

  task automatic add_vec(input logic c0, input logic w0, input logic o0, input logic [7:0] a0,
                         input word_t d0, input logic c1, input logic w1, input logic o1,
                         input logic [7:0] a1, input word_t d1, input word_t e0, input word_t e1);
    vec_t v;
    v.c0 = c0; v.w0 = w0; v.o0 = o0; v.a0 = a0; v.d0 = d0;
    v.c1 = c1; v.w1 = w1; v.o1 = o1; v.a1 = a1; v.d1 = d1;
    v.exp0 = e0; v.exp1 = e1;
    vecs.push_back(v);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    idle_inputs();
    model_clear();
    reset = 1'b0;

    // Reset state
    #3;
    chk("reset_out0", data_0_out, 16'h0000);
    chk("reset_out1", data_1_out, 16'h0000);
    @(negedge clk);
    reset = 1'b1;

    // Burst fill two consecutive words per cycle, then read pairs back
    for (int i = 0; i <= 128; i += 2) begin
      apply(1, 1, 0, 8'(i), 16'(i), 1, 1, 0, 8'(i + 1), 16'(i + 1));
    end
    for (int i = 0; i <= 128; i += 2) begin
      apply(1, 0, 1, 8'(i), '0, 1, 0, 1, 8'(i + 1), '0);
      chk($sformatf("burst_rd0_%0d", i), data_0_out, 16'(i));
      chk($sformatf("burst_rd1_%0d", i + 1), data_1_out, 16'(i + 1));
    end

    // Directed corner cases; outputs start at 128 / 129 from the last burst read
    add_vec(1, 1, 0, 8'd5,   16'h1234, 0, 0, 0, 8'd0,   16'h0000, 16'd128,  16'd129);  // mem[5]=1234
    add_vec(1, 0, 1, 8'd5,   16'h0000, 0, 0, 0, 8'd0,   16'h0000, 16'h1234, 16'd129);
    add_vec(0, 1, 1, 8'd5,   16'hFFFF, 0, 0, 0, 8'd0,   16'h0000, 16'h1234, 16'd129);  // cs off: no write
    add_vec(1, 0, 0, 8'd7,   16'h0000, 1, 0, 1, 8'd5,   16'h0000, 16'h1234, 16'h1234); // oe off: hold
    add_vec(1, 0, 1, 8'd5,   16'h0000, 0, 0, 0, 8'd0,   16'h0000, 16'h1234, 16'h1234);
    add_vec(1, 1, 1, 8'd10,  16'hAAAA, 1, 1, 1, 8'd10,  16'h5555, 16'h1234, 16'h1234); // collision
    add_vec(1, 0, 1, 8'd10,  16'h0000, 1, 0, 1, 8'd10,  16'h0000, 16'h5555, 16'h5555);
    add_vec(1, 1, 0, 8'd20,  16'h0001, 0, 0, 0, 8'd0,   16'h0000, 16'h5555, 16'h5555);
    add_vec(1, 0, 1, 8'd20,  16'h0000, 1, 1, 1, 8'd20,  16'h0002, 16'h0001, 16'h5555); // read old
    add_vec(1, 0, 1, 8'd20,  16'h0000, 1, 0, 1, 8'd20,  16'h0000, 16'h0002, 16'h0002);
    add_vec(1, 1, 0, 8'd255, 16'hBEEF, 1, 1, 0, 8'd0,   16'hCAFE, 16'h0002, 16'h0002);
    add_vec(1, 0, 1, 8'd0,   16'h0000, 1, 0, 1, 8'd255, 16'h0000, 16'hCAFE, 16'hBEEF);
    add_vec(1, 0, 1, 8'd255, 16'h0000, 1, 0, 1, 8'd0,   16'h0000, 16'hBEEF, 16'hCAFE);
    add_vec(1, 0, 0, 8'd3,   16'h0000, 0, 0, 1, 8'd3,   16'h0000, 16'hBEEF, 16'hCAFE);
    foreach (vecs[k]) begin
      apply(vecs[k].c0, vecs[k].w0, vecs[k].o0, vecs[k].a0, vecs[k].d0,
            vecs[k].c1, vecs[k].w1, vecs[k].o1, vecs[k].a1, vecs[k].d1);
      chk($sformatf("vec%0d_out0", k), data_0_out, vecs[k].exp0);
      chk($sformatf("vec%0d_out1", k), data_1_out, vecs[k].exp1);
    end

    // Mid-cycle reset clears outputs at once and ignores a write while low
    #2;
    reset = 1'b0;
    #1;
    chk("midrst_out0", data_0_out, 16'h0000);
    chk("midrst_out1", data_1_out, 16'h0000);
    @(negedge clk);
    cs_0 = 1; we_0 = 1; address_0 = 8'd1; data_0_in = 16'h7777;
    cs_1 = 1; we_1 = 0; oe_1 = 1; address_1 = 8'd10;
    @(posedge clk);
    #1;
    chk("rst_hold_out1", data_1_out, 16'h0000);
    @(negedge clk);
    idle_inputs();
    reset = 1'b1;
    model_clear();
    apply(1, 0, 1, 8'd5,   '0, 1, 0, 1, 8'd255, '0);
    chk("post_rst_rd5",   data_0_out, 16'h0000);
    chk("post_rst_rd255", data_1_out, 16'h0000);
    apply(1, 0, 1, 8'd1,   '0, 1, 0, 1, 8'd10,  '0);
    chk("post_rst_rd1",   data_0_out, 16'h0000);
    chk("post_rst_rd10",  data_1_out, 16'h0000);

    // Randomized traffic with narrow address windows to force collisions
    for (int n = 0; n < 400; n++) begin
      logic [7:0] ra0, ra1;
      if (n % 2 == 0) begin
        ra0 = 8'($urandom_range(0, 7));
        ra1 = 8'($urandom_range(0, 7));
      end else begin
        ra0 = 8'($urandom);
        ra1 = 8'($urandom);
      end
      apply(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom), ra0, 16'($urandom),
            1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom), ra1, 16'($urandom));
      chk($sformatf("rand%0d_out0", n), data_0_out, mout0);
      chk($sformatf("rand%0d_out1", n), data_1_out, mout1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
